// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage stall/flush generation, control registers,
// interrupt detection and exception entry/return sequencing for the 5-stage core.
module pipe_ctrl #(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    input  logic [IRQ_W-1:0] irq,
    input  logic [29:0]      mem_pc,
    input  logic             mem_en,
    input  logic             mem_br_flag,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       mem_dst_addr,
    input  logic [2:0]       mem_exp_code,
    input  logic [31:0]      mem_out,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    output logic             exe_mode,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc,
    output logic             int_detect
);

    localparam logic [1:0] OP_WRCR = 2'd1;
    localparam logic [1:0] OP_EXRT = 2'd2;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e           state_q, state_d;
    logic             exe_mode_q, exe_mode_d;
    logic             int_en_q, int_en_d;
    logic [1:0]       pre_status_q, pre_status_d;
    logic [29:0]      epc_q, epc_d;
    logic [29:0]      exp_vector_q, exp_vector_d;
    logic [3:0]       cause_q, cause_d;
    logic [IRQ_W-1:0] int_mask_q, int_mask_d;

    logic stall, accept, take_exp, take_exrt, take_wrcr;

    assign stall     = if_busy | mem_busy;
    assign accept    = (state_q == RUN) && !stall && mem_en;
    assign take_exp  = accept && (mem_exp_code != 3'd0);
    assign take_exrt = accept && (mem_exp_code == 3'd0) && (mem_ctrl_op == OP_EXRT);
    assign take_wrcr = accept && (mem_exp_code == 3'd0) && (mem_ctrl_op == OP_WRCR);

    assign if_stall   = stall | ld_hazard;
    assign id_stall   = stall;
    assign ex_stall   = stall;
    assign mem_stall  = stall;
    assign exe_mode   = exe_mode_q;
    assign int_detect = int_en_q & |(irq & ~int_mask_q);

    // Flush/redirect controls are combinational so the pipeline registers
    // consume them on the same edge that commits the control registers.
    always_comb begin
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        new_pc    = 30'd0;
        if (state_q == FLUSH) begin
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (take_exp) begin
            {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
            new_pc = exp_vector_q;
        end else if (take_exrt) begin
            {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
            new_pc = epc_q;
        end else if (ld_hazard && !stall) begin
            id_flush = 1'b1;
        end
    end

    always_comb begin
        creg_rd_data = 32'd0;
        case (creg_rd_addr)
            5'd0: creg_rd_data = {30'd0, int_en_q, exe_mode_q};
            5'd1: creg_rd_data = {30'd0, pre_status_q};
            5'd2: creg_rd_data = {epc_q, 2'b00};
            5'd3: creg_rd_data = {exp_vector_q, 2'b00};
            5'd4: creg_rd_data = {28'd0, cause_q};
            5'd5: creg_rd_data = {{(32-IRQ_W){1'b0}}, int_mask_q};
            5'd6: creg_rd_data = {{(32-IRQ_W){1'b0}}, irq};
            default: creg_rd_data = 32'd0;
        endcase
    end

    // NOTE: every _d defaults to its _q first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        exe_mode_d   = exe_mode_q;
        int_en_d     = int_en_q;
        pre_status_d = pre_status_q;
        epc_d        = epc_q;
        exp_vector_d = exp_vector_q;
        cause_d      = cause_q;
        int_mask_d   = int_mask_q;
        if (state_q == FLUSH) begin
            state_d = RUN;
        end else if (take_exp) begin
            // An instruction in a delay slot restarts at its branch.
            epc_d        = mem_br_flag ? mem_pc - 30'd1 : mem_pc;
            cause_d      = {mem_br_flag, mem_exp_code};
            pre_status_d = {int_en_q, exe_mode_q};
            exe_mode_d   = 1'b0;
            int_en_d     = 1'b0;
            state_d      = FLUSH;
        end else if (take_exrt) begin
            {int_en_d, exe_mode_d} = pre_status_q;
            state_d = FLUSH;
        end else if (take_wrcr) begin
            case (mem_dst_addr)
                5'd0: {int_en_d, exe_mode_d} = mem_out[1:0];
                5'd1: pre_status_d = mem_out[1:0];
                5'd2: epc_d        = mem_out[31:2];
                5'd3: exp_vector_d = mem_out[31:2];
                5'd4: cause_d      = mem_out[3:0];
                5'd5: int_mask_d   = mem_out[IRQ_W-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            exe_mode_q   <= 1'b0;
            int_en_q     <= 1'b0;
            pre_status_q <= 2'd0;
            epc_q        <= 30'd0;
            exp_vector_q <= 30'd0;
            cause_q      <= 4'd0;
            int_mask_q   <= {IRQ_W{1'b1}};
        end else begin
            state_q      <= state_d;
            exe_mode_q   <= exe_mode_d;
            int_en_q     <= int_en_d;
            pre_status_q <= pre_status_d;
            epc_q        <= epc_d;
            exp_vector_q <= exp_vector_d;
            cause_q      <= cause_d;
            int_mask_q   <= int_mask_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, WRCR, exceptions,
// EXRT, stall blocking, interrupt detection and reset during FLUSH.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy, mem_busy, ld_hazard;
    logic [7:0]  irq;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;
    logic        int_detect;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.IRQ_W(8)) dut (
        .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_hazard(ld_hazard), .irq(irq), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out), .creg_rd_addr(creg_rd_addr),
        .creg_rd_data(creg_rd_data), .exe_mode(exe_mode),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
        .int_detect(int_detect)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_en = 1'b0; mem_ctrl_op = 2'd0; mem_exp_code = 3'd0;
        mem_br_flag = 1'b0; mem_pc = 30'd0; mem_dst_addr = 5'd0; mem_out = 32'd0;
    endtask

    task automatic wrcr(input logic [4:0] dst, input logic [31:0] data);
        mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_exp_code = 3'd0;
        mem_dst_addr = dst; mem_out = data;
    endtask

    function automatic logic [31:0] flushes();
        return {28'd0, if_flush, id_flush, ex_flush, mem_flush};
    endfunction

    function automatic logic [31:0] stalls();
        return {28'd0, if_stall, id_stall, ex_stall, mem_stall};
    endfunction

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        creg_rd_addr = addr;
        #1;
        check(tag, creg_rd_data, exp);
    endtask

    initial begin
        reset = 1'b1; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
        irq = 8'h00; creg_rd_addr = 5'd0;
        idle();
        tick(); tick();

        // Reset state
        #1;
        check("rst_flush", flushes(), 32'h0);
        check("rst_stall", stalls(), 32'h0);
        check("rst_new_pc", {2'b0, new_pc}, 32'h0);
        check("rst_int_detect", {31'd0, int_detect}, 32'h0);
        rd_check("rst_mask", 5'd5, 32'hFF);
        reset = 1'b0;

        // exp_vector = 0x100; WRCR does not flush
        wrcr(5'd3, 32'h400);
        #1;
        check("wrcr_no_flush", flushes(), 32'h0);
        rd_check("wrcr_no_bypass", 5'd3, 32'h0);
        tick(); idle();
        rd_check("exp_vector", 5'd3, 32'h400);

        // status = user mode, interrupts on
        wrcr(5'd0, 32'h3);
        tick(); idle();
        #1;
        check("exe_mode_user", {31'd0, exe_mode}, 32'h1);

        // OVERFLOW at 0x20
        mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h20;
        #1;
        check("ovf_flush", flushes(), 32'hF);
        check("ovf_new_pc", {2'b0, new_pc}, 32'h100);
        tick();
        // FLUSH state: ignores an exception sitting in MEM
        mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h55;
        #1;
        check("flush_state_flush", flushes(), 32'h6);
        check("flush_state_new_pc", {2'b0, new_pc}, 32'h0);
        rd_check("ovf_epc", 5'd2, 32'h80);
        rd_check("ovf_cause", 5'd4, 32'h3);
        rd_check("ovf_status", 5'd0, 32'h0);
        rd_check("ovf_pre_status", 5'd1, 32'h3);
        tick(); idle();
        rd_check("flush_ignored_cause", 5'd4, 32'h3);
        check("back_to_run", flushes(), 32'h0);

        // TRAP in delay slot at pc 0 -> wrap
        mem_en = 1'b1; mem_exp_code = 3'd5; mem_br_flag = 1'b1; mem_pc = 30'h0;
        #1;
        check("trap_flush", flushes(), 32'hF);
        tick(); idle();
        rd_check("trap_epc_wrap", 5'd2, 32'hFFFF_FFFC);
        rd_check("trap_cause", 5'd4, 32'hD);
        tick();

        // Interrupt detection
        wrcr(5'd0, 32'h2);
        tick();
        wrcr(5'd5, 32'hFE);
        irq = 8'h01;
        #1;
        check("int_mask_delay", {31'd0, int_detect}, 32'h0);
        tick(); idle();
        #1;
        check("int_detect_on", {31'd0, int_detect}, 32'h1);
        rd_check("irq_read", 5'd6, 32'h01);
        irq = 8'h02;
        #1;
        check("int_detect_masked", {31'd0, int_detect}, 32'h0);
        irq = 8'h00;

        // Exception blocked by mem_busy for 3 cycles
        wrcr(5'd2, 32'h100);
        tick();
        mem_en = 1'b1; mem_ctrl_op = 2'd0; mem_exp_code = 3'd2; mem_pc = 30'h30;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_stall", stalls(), 32'hF);
            check("busy_no_flush", flushes(), 32'h0);
            tick();
            rd_check("busy_epc_hold", 5'd2, 32'h100);
        end
        mem_busy = 1'b0;
        #1;
        check("busy_taken_flush", flushes(), 32'hF);
        check("busy_taken_new_pc", {2'b0, new_pc}, 32'h100);
        tick(); idle();
        rd_check("busy_epc", 5'd2, 32'hC0);
        rd_check("busy_pre_status", 5'd1, 32'h2);
        tick();

        // EXRT
        wrcr(5'd1, 32'h3);
        tick();
        wrcr(5'd2, 32'h100);
        tick();
        mem_en = 1'b1; mem_ctrl_op = 2'd2;
        #1;
        check("exrt_flush", flushes(), 32'hF);
        check("exrt_new_pc", {2'b0, new_pc}, 32'h40);
        tick(); idle();
        rd_check("exrt_status", 5'd0, 32'h3);

        // Reset during FLUSH
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_flush_flush", flushes(), 32'h0);
        rd_check("rst_in_flush_status", 5'd0, 32'h0);
        rd_check("rst_in_flush_mask", 5'd5, 32'hFF);
        rd_check("undef_index", 5'd7, 32'h0);

        // Load-use hazard
        ld_hazard = 1'b1;
        #1;
        check("ld_stall", stalls(), 32'h8);
        check("ld_flush", flushes(), 32'h4);
        mem_busy = 1'b1;
        #1;
        check("ld_busy_flush", flushes(), 32'h0);
        mem_busy = 1'b0; ld_hazard = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 5-stage core. It generates per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and detects external interrupts for the EX stage. It owns the control registers (status, interrupt mask, exception vector, EPC, exception code) and sequences exception entry and exception return. It sits beside the pipeline and samples the MEM-stage outputs of the EX/MEM register.

## Interface
- IRQ_W, 8, number of external interrupt lines
- Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_busy  in  1  instruction fetch bus not ready
- mem_busy  in  1  data bus access not ready
- ld_hazard  in  1  load-use hazard detected in ID
- irq  in  IRQ_W  external interrupt requests, level-sensitive
- mem_pc  in  30  word PC of the instruction in MEM
- mem_en  in  1  MEM instruction valid
- mem_br_flag  in  1  MEM instruction sits in a branch delay slot
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT
- mem_dst_addr  in  5  control register index for WRCR
- mem_exp_code  in  3  0 none, 1 EXT_INT, 2 UNDEF, 3 OVERFLOW, 4 MISA, 5 TRAP, 6 PRV_VIO
- mem_out  in  32  WRCR write data
- creg_rd_addr  in  5  control register read index
- creg_rd_data  out  32  read data, combinational
- exe_mode  out  1  0 kernel, 1 user
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage hold
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage bubble insert
- new_pc  out  30  redirect target, valid while if_flush=1
- int_detect  out  1  unmasked interrupt pending and enabled

## Operation
- Control registers:
  - 0 STATUS: bit0 exe_mode, bit1 int_en.
  - 1 PRE_STATUS: same layout; holds the pre-exception copy.
  - 2 PC: the EPC, in bits 31:2.
  - 3 EXP_VECTOR: bits 31:2.
  - 4 CAUSE: bits 2:0 = exp_code, bit3 = br_flag.
  - 5 INT_MASK: bits IRQ_W-1:0; a bit value of 1 masks that interrupt.
  - 6 IRQ: raw irq, read-only.
  - Any other index reads 0.
- Reset values: exe_mode=0, int_en=0, pre_status=0, epc=0, exp_vector=0, cause=0, int_mask=all 1s.
- Control outputs at reset: all stalls=0, all flushes=0, new_pc=0, int_detect=0.
- stall = if_busy | mem_busy.
  - if_stall = stall | ld_hazard.
  - id_stall, ex_stall, mem_stall = stall.
- int_detect = int_en & |(irq & ~int_mask). It is combinational from registered state and irq. The EX stage turns it into an EXT_INT exception.
- FSM states:
  - RUN.
  - FLUSH: a one-cycle cleanup after a redirect. It forces id_flush=1 and ex_flush=1 regardless of inputs, and ignores mem_ctrl_op and mem_exp_code. It always returns to RUN on the next cycle.
- An event is accepted only in RUN, with stall=0 and mem_en=1. Priority, highest first:
  1. Exception: mem_exp_code≠0.
     - All four flushes=1 and new_pc=exp_vector.
     - On the clock edge: epc = mem_br_flag ? mem_pc-1 : mem_pc (30-bit wrap), cause={mem_br_flag, code}, pre_status=status, exe_mode=0, int_en=0.
     - Next state: FLUSH.
  2. EXRT: all flushes=1 and new_pc=epc. On the edge: status=pre_status. Next state: FLUSH.
  3. WRCR: the selected register is updated from mem_out. Writes to index 6 and to undefined indices are ignored. No flush occurs.
- ld_hazard with no event gives id_flush=1, so a bubble enters ID/EX while IF holds.
- A stall blocks event acceptance. Outputs and registers hold until the stall clears. Flush outputs are 0 during a stall, except in FLUSH state.
- Reset asserted in any state forces RUN and the reset values on the next edge.

## Timing
- Flush, new_pc and stall outputs are combinational in the cycle the event sits in MEM. The pipeline registers consume them at the same edge where the control registers update.
- Exception-to-redirect latency: 0 cycles (same cycle). The vector instruction is fetched in the following cycle.
- The FLUSH state lasts exactly 1 cycle. Back-to-back events are impossible because MEM holds a bubble during FLUSH.
- creg_rd_data reflects a WRCR from the next cycle; there is no write-through bypass.
- int_detect reflects an irq or mask change in the same cycle. A mask change by WRCR takes effect one cycle later.

## Test plan
- Reset, then exp_vector=0x100 via WRCR (mem_out=0x400, dst=3). Inject OVERFLOW at mem_pc=0x20 -> all flushes=1 and new_pc=0x100 that cycle. Then epc=0x20, cause=3, int_en=0. FLUSH for 1 cycle, then RUN.
- TRAP with mem_br_flag=1 at mem_pc=0x0 -> epc=0x3FFFFFFF (wrap), cause=0xD.
- Set status int_en=1, int_mask=0xFE, irq=0x01 -> int_detect=1. Then irq=0x02 -> int_detect=0.
- Exception in MEM with mem_busy=1 for 3 cycles -> all stalls=1, no flush, registers unchanged. Taken on the 4th cycle.
- EXRT with pre_status=0x3 and epc=0x40 -> new_pc=0x40, all flushes=1, status=0x3 next cycle.
- ld_hazard=1 with stall=0 -> if_stall=1 and id_flush=1, other flushes=0. Reset asserted during FLUSH -> RUN and reset values next cycle.
